sum4_sequencer: RTL and testbench
=================================

SUM4_SEQUENCER -- requirements
Module: sum4_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/c/d presented.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-006 SHALL have ports a, b, c, d  input  W each  unsigned operands.
REQ-007 SHALL have port out_valid  output  1  sum is valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts sum.
REQ-009 SHALL have port sum  output  W+2  registered a+b+c+d.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL contain exactly one adder, with two (W+1)-bit inputs and a (W+2)-bit result, time-shared across all partial sums.
REQ-012 SHALL implement FSM states IDLE, AB, CD, FIN, OUT.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in OUT.
REQ-014 IDLE: in_valid&in_ready captures a, b, c, d into internal registers, then goes to AB; otherwise stays in IDLE.
REQ-015 AB: adder computes zero-extended a+b into a (W+1)-bit register ab, then goes to CD.
REQ-016 CD: adder computes c+d into a (W+1)-bit register cd, then goes to FIN.
REQ-017 FIN: adder computes ab+cd into sum without truncation (W+2 bits), then goes to OUT.
REQ-018 Latency: accept on edge k SHALL result in out_valid=1 with the correct sum after edge k+3.
REQ-019 OUT: out_valid&out_ready returns the FSM to IDLE; otherwise it stays in OUT.
REQ-020 While in OUT, sum SHALL be held stable and SHALL NOT change until the handshake completes.
REQ-021 Changes on a/b/c/d or in_valid after capture SHALL NOT affect the result in progress.
REQ-022 Minimum initiation interval SHALL be 5 cycles: in_ready SHALL NOT be asserted in OUT, even when out_ready=1.
REQ-023 The sum register SHALL retain its last value in IDLE, AB and CD.

Reset
REQ-024 rst_n=0 at an edge SHALL force state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, and ab, cd and captured operands to 0.
REQ-025 Reset asserted in any state, including mid-operation or in OUT with out_valid=1, SHALL discard the operation in progress without producing a result.
REQ-026 in_valid SHALL be ignored on a cycle where rst_n=0.

Configuration
REQ-027 Macro SUM4_SEQ_CNT_EN, when defined, SHALL add port done_cnt  output  16  count of completed output handshakes.
REQ-028 With SUM4_SEQ_CNT_EN defined, done_cnt SHALL increment by 1 on each out_valid&out_ready, wrap 0xFFFF->0x0000, and reset to 0.
REQ-029 Without SUM4_SEQ_CNT_EN, the done_cnt port and its counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0, sum=0, no capture.
REQ-031 Max operands: W=8, a=b=c=d=0xFF accepted at edge k -> out_valid=1 after edge k+3, sum=0x3FC.
REQ-032 Backpressure: a=1, b=2, c=3, d=4 with out_ready=0 for 6 cycles -> sum=10 held stable, in_ready=0, busy=1; out_ready=1 -> IDLE on the next edge.
REQ-033 Operand isolation: after accepting 10, 20, 30, 40, drive a..d=0xFF during AB/CD/FIN -> sum=100.
REQ-034 Reset mid-operation: pulse rst_n=0 in CD -> IDLE, out_valid never asserts, next set 5, 5, 5, 5 -> sum=20.
REQ-035 Counter (macro defined): force 0xFFFF completions, or preload the counter in simulation -> done_cnt wraps to 0x0000 on the next completion.

Source files
------------

// File: rtl/sum4_sequencer_if.sv
// sum4_sequencer_if: operand/result handshake bundle for sum4_sequencer.
interface sum4_sequencer_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] sum;
  logic         busy;
  modport master (output in_valid, a, b, c, d, out_ready, input in_ready, out_valid, sum, busy);
  modport slave  (input in_valid, a, b, c, d, out_ready, output in_ready, out_valid, sum, busy);
endinterface

// File: rtl/sum4_sequencer.sv
// sum4_sequencer: a+b+c+d through one time-shared adder over IDLE/AB/CD/FIN/OUT.
// Optional SUM4_SEQ_CNT_EN adds the done_cnt output handshake counter.
module sum4_sequencer #(parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  sum4_sequencer_if.slave bus
`ifdef SUM4_SEQ_CNT_EN
  , output logic [15:0] done_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, AB, CD, FIN, OUT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [W:0] ab_q, ab_d, cd_q, cd_d, add_x, add_y;
  logic [W+1:0] sum_q, sum_d, add_r;
  logic take, give;
  assign take = bus.in_valid && state_q == IDLE;
  assign give = bus.out_ready && state_q == OUT;
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.busy = state_q != IDLE;
  assign bus.sum = sum_q;
  // the single adder: operand muxes select the partial sum for the current state
  always_comb begin
    add_x = state_q == FIN ? ab_q : state_q == CD ? {1'b0, c_q} : {1'b0, a_q};
    add_y = state_q == FIN ? cd_q : state_q == CD ? {1'b0, d_q} : {1'b0, b_q};
    add_r = {1'b0, add_x} + {1'b0, add_y};
    a_d = take ? bus.a : a_q;
    b_d = take ? bus.b : b_q;
    c_d = take ? bus.c : c_q;
    d_d = take ? bus.d : d_q;
    ab_d = state_q == AB ? add_r[W:0] : ab_q;
    cd_d = state_q == CD ? add_r[W:0] : cd_q;
    sum_d = state_q == FIN ? add_r : sum_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = take ? AB : IDLE;
      AB:      state_d = CD;
      CD:      state_d = FIN;
      FIN:     state_d = OUT;
      OUT:     state_d = give ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      ab_q <= '0;
      cd_q <= '0;
      sum_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      ab_q <= ab_d;
      cd_q <= cd_d;
      sum_q <= sum_d;
    end
  end
`ifdef SUM4_SEQ_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = give ? cnt_q + 16'd1 : cnt_q;
  assign done_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_sum4_sequencer.sv
// tb_sum4_sequencer: directed and random operand sets against an arithmetic reference.
module tb_sum4_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int fails = 0;
  int prev = 0;
  int hs = 0;
  sum4_sequencer_if #(.W(8)) bus();
`ifdef SUM4_SEQ_CNT_EN
  logic [15:0] done_cnt;
  sum4_sequencer #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .done_cnt(done_cnt));
`else
  sum4_sequencer #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                     input logic [7:0] id, input int hold, input bit iso);
    int e;
    e = int'(ia) + int'(ib) + int'(ic) + int'(id);
    bus.a = ia;
    bus.b = ib;
    bus.c = ic;
    bus.d = id;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    chk("idle_in_ready", bus.in_ready, 1);
    step();
    if (iso) begin
      bus.a = 8'hFF;
      bus.b = 8'hFF;
      bus.c = 8'hFF;
      bus.d = 8'hFF;
    end else bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_mid", bus.busy, 1);
      chk("in_ready_mid", bus.in_ready, 0);
      chk("out_valid_early", bus.out_valid, 0);
      chk("sum_retain", bus.sum, prev);
      step();
    end
    bus.in_valid = 1'b0;
    chk("out_valid_k3", bus.out_valid, 1);
    chk("sum_k3", bus.sum, e);
    chk("in_ready_out", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_sum", bus.sum, e);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_busy", bus.busy, 1);
    end
    bus.out_ready = 1'b1;
    step();
    hs++;
    prev = e;
    bus.out_ready = 1'b0;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_busy", bus.busy, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_sum", bus.sum, e);
`ifdef SUM4_SEQ_CNT_EN
    chk("done_cnt", done_cnt, hs);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.c = 8'($urandom);
    bus.d = 8'($urandom);
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sum", bus.sum, 0);
`ifdef SUM4_SEQ_CNT_EN
    chk("rst_done_cnt", done_cnt, 0);
`endif
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    chk("rst_no_capture", bus.busy, 0);
    run(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0);
    run(8'd1, 8'd2, 8'd3, 8'd4, 6, 1'b0);
    run(8'd10, 8'd20, 8'd30, 8'd40, 1, 1'b1);
    bus.a = 8'd9;
    bus.b = 8'd9;
    bus.c = 8'd9;
    bus.d = 8'd9;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    prev = 0;
    hs = 0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_sum", bus.sum, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mid_rst_no_out", bus.out_valid, 0);
      step();
    end
    run(8'd5, 8'd5, 8'd5, 8'd5, 1, 1'b0);
    for (int i = 0; i < 10; i++)
      run(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
